// File: rtl/hidden_cpu_host.sv
// hidden_cpu_host: buffers 6-bit instruction words, then drives them into a
// pin-level CPU as a slow software-generated clock. Each instruction gets one
// low phase and one high phase. On the last cycle of the high phase, the CPU
// output pins are sampled into result.
// Optional feature macro HIDDEN_CPU_HOST_CPURST_EN: when it is defined, every
// run starts with one full CPU clock that has CPU reset held high.
module hidden_cpu_host #(
  parameter int DEPTH = 16,
  parameter int HALF  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [5:0] load_data,
  output logic       load_ready,
  input  logic       clear,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] cpu_io_in,
  input  logic [7:0] cpu_io_out,
  output logic [7:0] result,
  output logic       result_valid
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;

`ifdef HIDDEN_CPU_HOST_CPURST_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CPURST_LO, S_CPURST_HI, S_ISSUE_LO, S_ISSUE_HI, S_FINISH
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE_LO, S_ISSUE_HI, S_FINISH
  } state_t;
`endif

  state_t         r_state, w_next;
  logic [5:0]     r_buf [DEPTH];
  logic [CW-1:0]  r_count;
  logic [IW-1:0]  r_index;
  logic [PW-1:0]  r_phase;
  logic [7:0]     r_result;
  logic           r_result_valid;

  logic           w_phase_last;
  logic           w_last_instr;
  logic           w_load;
  logic           w_start;
  logic           w_sample;

  assign w_phase_last = (r_phase == PW'(HALF - 1));
  assign w_last_instr = ({1'b0, r_index} == (r_count - CW'(1)));
  assign load_ready   = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
  assign w_load       = load_valid && load_ready;
  // A clear in the same cycle wins. Launching a run on a buffer that is
  // being emptied would leave the index compare with nothing to match.
  assign w_start      = (r_state == S_IDLE) && start && !clear && (r_count != '0);
  assign w_sample     = (r_state == S_ISSUE_HI) && w_phase_last;

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FINISH);
  assign result       = r_result;
  assign result_valid = r_result_valid;

  // Next-state logic: phase states advance when their HALF-cycle dwell ends.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
`ifdef HIDDEN_CPU_HOST_CPURST_EN
          w_next = S_CPURST_LO;
`else
          w_next = S_ISSUE_LO;
`endif
        end
      end
`ifdef HIDDEN_CPU_HOST_CPURST_EN
      S_CPURST_LO: if (w_phase_last) w_next = S_CPURST_HI;
      S_CPURST_HI: if (w_phase_last) w_next = S_ISSUE_LO;
`endif
      S_ISSUE_LO:  if (w_phase_last) w_next = S_ISSUE_HI;
      S_ISSUE_HI:  if (w_phase_last) w_next = w_last_instr ? S_FINISH : S_ISSUE_LO;
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // CPU pin drive is decoded from state only, so it is clean between edges.
  always_comb begin
    cpu_io_in = 8'h00;
    case (r_state)
`ifdef HIDDEN_CPU_HOST_CPURST_EN
      S_CPURST_LO: cpu_io_in = 8'h02;
      S_CPURST_HI: cpu_io_in = 8'h03;
`endif
      S_ISSUE_LO:  cpu_io_in = {r_buf[r_index], 2'b00};
      S_ISSUE_HI:  cpu_io_in = {r_buf[r_index], 2'b01};
      default:     cpu_io_in = 8'h00;
    endcase
  end

  // State register. The phase counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state || r_state == S_IDLE) r_phase <= '0;
      else                                        r_phase <= r_phase + PW'(1);
    end
  end

  // Buffer fill level and the run's instruction index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_index <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (clear)       r_count <= '0;
        else if (w_load) r_count <= r_count + CW'(1);
      end
      if (w_start)                       r_index <= '0;
      else if (w_sample && !w_last_instr) r_index <= r_index + IW'(1);
    end
  end

  // Buffer storage. Validity is tracked by r_count, so the storage has no reset.
  always_ff @(posedge clk) begin
    if (w_load && !clear) r_buf[r_count[IW-1:0]] <= load_data;
  end

  // Capture the CPU pins at the end of each high phase, and pulse valid once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result       <= 8'h00;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_sample;
      if (w_sample) r_result <= cpu_io_out;
    end
  end

endmodule

// File: tb/tb_hidden_cpu_host.sv
// Directed bench for hidden_cpu_host (DEPTH=16, HALF=2). It follows the
// build's HIDDEN_CPU_HOST_CPURST_EN setting for the CPU-reset preamble.
module tb_hidden_cpu_host;
  localparam int H = 2;
  localparam int D = 16;
`ifdef HIDDEN_CPU_HOST_CPURST_EN
  localparam int P = 2 * H;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, load_valid, clear, start;
  logic [5:0] load_data;
  logic [7:0] cpu_io_out;
  logic       load_ready, busy, done, result_valid;
  logic [7:0] cpu_io_in, result;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] prog [20];

  hidden_cpu_host #(.DEPTH(D), .HALF(H)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .clear(clear), .start(start), .busy(busy), .done(done),
    .cpu_io_in(cpu_io_in), .cpu_io_out(cpu_io_out),
    .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Value presented on the CPU output pins at the end of instruction k.
  function automatic logic [7:0] res_val(input int k);
    return (k == 1) ? 8'hA5 : 8'(8'h30 + k);
  endfunction

  task automatic load_word(input logic [5:0] d);
    chk("load_ready_pre", 32'(load_ready), 1);
    load_valid = 1'b1;
    load_data  = d;
    tick;
    load_valid = 1'b0;
  endtask

  // Runs the buffered program of n words (prog[0..n-1]). The checks cover
  // each cycle's pins, busy, done and result. mid>=0 pulses start+clear in
  // that run cycle. abort asserts rst in the first cycle of the 2nd ISSUE_LO.
  task automatic run_prog(input int n, input int mid, input bit abort);
    int len, pulses, q, k;
    logic [7:0] exp_io;
    len    = P + 2 * H * n;
    pulses = 0;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    for (int j = 0; j <= len; j++) begin
      exp_io = 8'h00;
      if (j < P) exp_io = (j < H) ? 8'h02 : 8'h03;
      else if (j < len) begin
        q = j - P;
        k = q / (2 * H);
        exp_io = {prog[k], 1'b0, ((q % (2 * H)) >= H)};
      end
      chk("cpu_io_in", 32'(cpu_io_in), 32'(exp_io));
      chk("busy", 32'(busy), 1);
      chk("done", 32'(done), 32'(j == len));
      chk("load_ready_run", 32'(load_ready), 0);
      if (j > P && ((j - P) % (2 * H)) == 0) begin
        chk("result_valid", 32'(result_valid), 1);
        chk("result", 32'(result), 32'(res_val((j - P) / (2 * H) - 1)));
      end else begin
        chk("result_valid", 32'(result_valid), 0);
      end
      if (result_valid) pulses++;
      cpu_io_out = 8'h00;
      if (j >= P && j < len && ((j - P) % (2 * H)) == 2 * H - 1)
        cpu_io_out = res_val((j - P) / (2 * H));
      start = (j == mid);
      clear = (j == mid);
      if (abort && j == P + 2 * H) begin
        rst = 1'b1;
        tick;
        rst = 1'b0; start = 1'b0; clear = 1'b0; cpu_io_out = 8'h00;
        chk("abort_io", 32'(cpu_io_in), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_rv", 32'(result_valid), 0);
        chk("abort_ready", 32'(load_ready), 1);
        for (int i = 0; i < 3; i++) begin
          tick;
          chk("abort_no_done", 32'(done), 0);
        end
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("empty_start_busy", 32'(busy), 0);
        chk("empty_start_io", 32'(cpu_io_in), 0);
        tick;
        chk("empty_start_busy2", 32'(busy), 0);
        return;
      end
      tick;
    end
    start = 1'b0; clear = 1'b0; cpu_io_out = 8'h00;
    chk("pulses", pulses, n);
    chk("post_busy", 32'(busy), 0);
    chk("post_done", 32'(done), 0);
    chk("post_io", 32'(cpu_io_in), 0);
    chk("post_rv", 32'(result_valid), 0);
    chk("post_ready", 32'(load_ready), 32'(n < D));
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; clear = 1'b0; start = 1'b0;
    load_data = 6'h00; cpu_io_out = 8'h00;
    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_io", 32'(cpu_io_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_rv", 32'(result_valid), 0);
    chk("rst_ready", 32'(load_ready), 1);

    // Three-word program, then a rerun with start/clear pulsed mid-run.
    prog[0] = 6'h05; prog[1] = 6'h1A; prog[2] = 6'h3F;
    for (int i = 0; i < 3; i++) load_word(prog[i]);
    run_prog(3, -1, 1'b0);
    run_prog(3, 5, 1'b0);

    // A clear with a simultaneous load leaves the buffer empty.
    clear = 1'b1; load_valid = 1'b1; load_data = 6'h2A;
    tick;
    clear = 1'b0; load_valid = 1'b0;
    prog[0] = 6'h00;
    load_word(prog[0]);
    run_prog(1, -1, 1'b0);

    // Overflow: 20 words offered, 16 taken.
    clear = 1'b1;
    tick;
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prog[i] = 6'(i + 7);
      load_valid = 1'b1;
      load_data  = prog[i];
      chk("ovf_ready", 32'(load_ready), 32'(i < D));
      tick;
    end
    load_valid = 1'b0;
    chk("ovf_ready_full", 32'(load_ready), 0);
    run_prog(16, -1, 1'b0);

    // Reset during the 2nd ISSUE_LO aborts the run and empties the buffer.
    run_prog(16, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hidden_cpu_host.md
HIDDEN_CPU_HOST -- requirements
Module: hidden_cpu_host

Interface
REQ-001 Parameters: DEPTH, default 16, instruction buffer entries (power of 2, 2..64); HALF, default 2, clk cycles per CPU clock phase (>=1).
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  instruction word offered for the buffer.
REQ-005 load_data  input  6  instruction {opcode[1:0], regA[1:0], regB[1:0]}.
REQ-006 load_ready  output  1  buffer accepts a word this cycle.
REQ-007 clear  input  1  empties the buffer (count to 0).
REQ-008 start  input  1  request to execute the buffered program.
REQ-009 busy  output  1  program run in progress.
REQ-010 done  output  1  one-cycle pulse at run end.
REQ-011 cpu_io_in  output  8  drives the CPU pins: [0]=CPU clock, [1]=CPU reset, [7:2]=instruction.
REQ-012 cpu_io_out  input  8  CPU output pins (r3 or pc).
REQ-013 result  output  8  last captured cpu_io_out.
REQ-014 result_valid  output  1  one-cycle pulse when result updates.

Function
REQ-015 States: IDLE, CPURST_LO, CPURST_HI, ISSUE_LO, ISSUE_HI, FINISH.
REQ-016 load_ready = 1 only in IDLE with count < DEPTH; load_valid && load_ready writes load_data to buffer[count] and increments count.
REQ-017 load_valid when load_ready = 0 is dropped with no state change; count saturates at DEPTH.
REQ-018 clear in IDLE sets count to 0 the next cycle; clear outside IDLE is ignored; clear has priority over a simultaneous load.
REQ-019 start in IDLE with count > 0 moves to CPURST_LO (macro defined) or ISSUE_LO (macro undefined) next cycle, sets busy, sets issue index to 0; start with count = 0, or while busy, is ignored.
REQ-020 Each phase state lasts exactly HALF cycles, tracked by a phase counter reloaded on every state entry.
REQ-021 CPURST_LO/CPURST_HI: cpu_io_in = {6'b0, 1'b1, 1'b0} then {6'b0, 1'b1, 1'b1}; then ISSUE_LO.
REQ-022 ISSUE_LO: cpu_io_in = {buffer[index], 1'b0, 1'b0}; ISSUE_HI: cpu_io_in = {buffer[index], 1'b0, 1'b1}; instruction bits remain stable across both phases.
REQ-023 On the last cycle of ISSUE_HI, cpu_io_out is registered into result, and result_valid pulses the following cycle.
REQ-024 After ISSUE_HI: if index = count-1, go to FINISH; otherwise increment index and go to ISSUE_LO.
REQ-025 FINISH lasts one cycle: done = 1, busy = 0 the following cycle, cpu_io_in = 0, return to IDLE.
REQ-026 Buffer contents and count are retained after a run; a subsequent start reruns the same program.
REQ-027 One run of N instructions takes 2*HALF*N cycles from ISSUE_LO entry to FINISH entry, plus 2*HALF cycles when the macro is defined.
REQ-028 cpu_io_in = 0 in IDLE; the CPU clock bit never toggles outside run states.

Reset
REQ-029 rst sets state IDLE, count 0, index 0, phase counter 0, cpu_io_in 0, result 0, result_valid 0, busy 0, done 0; load_ready = 1 the cycle after release.
REQ-030 rst mid-run aborts immediately: no done pulse, no result_valid pulse, CPU clock bit low the next cycle, buffer contents discarded (count = 0).
REQ-031 Buffer RAM contents are not required to reset; only count gates validity.

Configuration
REQ-032 Macro HIDDEN_CPU_HOST_CPURST_EN defined: every run begins with CPURST_LO/CPURST_HI, issuing one full CPU clock with CPU reset high; undefined: both states are removed and runs start at ISSUE_LO.

Verification
REQ-033 Reset, load 3 words 6'h05, 6'h1A, 6'h3F, start (HALF=2, macro defined) -> cpu_io_in sequence 02,02,03,03,14,14,15,15,68,68,69,69,FC,FC,FD,FD; done 17 cycles after the start cycle.
REQ-034 Drive cpu_io_out = 8'hA5 during the last cycle of the 2nd ISSUE_HI -> result = 8'hA5, result_valid high exactly 1 cycle, three pulses total per run.
REQ-035 Offer 20 words with load_valid held high -> 16 accepted, load_ready = 0 from the 17th, count = 16, extra words dropped.
REQ-036 Assert rst during the 2nd ISSUE_LO -> next cycle cpu_io_in = 0, busy = 0, no done pulse; start then ignored because count = 0.
REQ-037 start with empty buffer, and start pulsed mid-run -> no state change, busy unchanged, run completes normally.
REQ-038 Macro undefined, 1 word 6'h00, start -> first run cycle cpu_io_in = 00, done after 4 run cycles, no cycle with cpu_io_in[1] = 1.
